dram_timing_ctrl: RTL
=====================

Name: dram_timing_ctrl

Overview:
- Timing engine paired with the DRAM command FSM.
- Consumes the FSM's current command state and init request, and produces the completion strobes the FSM waits on: init_done, tACT_done, tRD_done, tWR_done, tPRE_done and tREF_done.
- Generates the periodic refresh request rf_req.
- Holds one shared command-latency counter, one init counter and one refresh-interval counter.

Parameters:
- CNT_W, 16, width of every internal counter.
- T_INIT, 200, cycles from init_req assertion to init_done.
- T_RCD, 4, ACTIVATE-to-done cycles.
- T_RD, 6, READ issue-to-done cycles (CL + burst).
- T_WR, 8, WRITE issue-to-done cycles (CWL + burst + write recovery).
- T_RP, 4, PRECHARGE-to-done cycles.
- T_RFC, 26, REFRESH-to-done cycles.
- T_REFI, 7800, cycles between refresh requests.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- cmd_state  in  cmd_fsm_t  current command FSM state (dram_pack).
- init_req  in  1  level request for the power-up init wait.
- init_done  out  1  sticky; high once the init wait completes.
- tACT_done  out  1  one-cycle pulse.
- tRD_done  out  1  one-cycle pulse.
- tWR_done  out  1  one-cycle pulse.
- tPRE_done  out  1  one-cycle pulse.
- tREF_done  out  1  one-cycle pulse.
- rf_req  out  1  refresh request level.
- busy  out  1  high while the shared counter is running.

Behaviour:
- Clocking and reset:
  - Single clock CLK.
  - RST is synchronous and active-high; it is sampled only on the CLK rising edge.
  - When RST is high, every output and counter clears to 0, the counter owner clears to NONE, and the refresh counter loads T_REFI-1.
- Issue cycle:
  - An issue cycle is any cycle in which cmd_state is ACTIVATE, READ, WRITE, PRECHARGE or REFRESH and cmd_state differed in the previous cycle. Edge detection uses a registered copy of cmd_state.
  - On an issue cycle, the shared counter loads T_x-1 and the owner register records the command.
- Counting and done strobes:
  - The counter decrements each cycle while nonzero.
  - When it reaches 0 with an owner recorded, the matching *_done output pulses for one cycle in the following cycle, and the owner returns to NONE.
  - Net latency: issue at cycle c gives the done pulse at cycle c+T_x.
- busy is high from the cycle after issue through the done-pulse cycle.
- New issue while busy: the counter reloads for the new command, ownership transfers, and the old command never produces its done pulse.
- Issue in the same cycle as an expiry: the expiring done pulse still fires, and the new load takes effect.
- T_x of 1 is legal: the done pulse fires the cycle after issue. A value of 0 is illegal and is flagged by an elaboration assertion.
- Init counter:
  - Starts on the rising edge of init_req.
  - init_done rises T_INIT cycles after that edge and stays high until RST.
  - If init_req drops mid-count, the count aborts and restarts on the next rising edge.
  - init_req while init_done is already high is ignored.
- Refresh counter:
  - Free-runs, starting only after init_done is high, and decrements every cycle.
  - At 0 it reloads T_REFI-1 and sets rf_req.
  - rf_req clears on a REFRESH issue cycle.
  - If expiry and a REFRESH issue occur in the same cycle, rf_req stays set (a new interval has elapsed).
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: DRAM_REF_POSTPONE_EN.
- With the macro defined:
  - A 4-bit pending counter tracks missed refreshes, saturating at 8.
  - Expiry increments it and a REFRESH issue decrements it; a simultaneous expiry and issue leaves it unchanged.
  - rf_req equals (pending != 0).
  - Extra output port rf_urgent (out, 1) is high when pending == 8.
- Without the macro:
  - rf_req is a single sticky bit.
  - Expiries that occur while rf_req is already set are dropped.
  - The rf_urgent port does not exist.

Test Plan:
- Init wait: RST for 2 cycles, then init_req=1 at cycle 5 with T_INIT=200 -> init_done rises at cycle 205 and stays high through 1000 cycles. Dropping init_req at cycle 100 in a rerun -> init_done never rises until init_req is re-asserted.
- Single command: ACTIVATE issued at cycle c -> tACT_done pulses at exactly c+4, width 1. READ at c -> tRD_done at c+6. WRITE -> tWR_done at c+8. PRECHARGE -> tPRE_done at c+4. REFRESH -> tREF_done at c+26. busy is 0 on the cycle after each pulse.
- Abort: ACTIVATE at c, PRECHARGE at c+2 -> no tACT_done; tPRE_done at c+6.
- Refresh request: with T_REFI=32, init_done at cycle t -> rf_req rises at t+32. A REFRESH issue at t+40 clears rf_req at t+41, and rf_req rises again at t+64.
- Postpone (macro on, T_REFI=16): no REFRESH for 8 intervals -> pending=8 and rf_urgent=1, with the 9th expiry saturating. One REFRESH issue -> pending=7 and rf_urgent=0. Macro off, same stimulus -> rf_req=1 and one REFRESH clears it.
- Reset mid-operation: RST asserted 2 cycles into a WRITE count -> no tWR_done, busy=0, rf_req=0 and init_done=0 the cycle after RST.

Source files
------------

// File: rtl/dram_timing_ctrl.sv
// dram_timing_ctrl: command latency, init wait and refresh interval timers.
// Define DRAM_REF_POSTPONE_EN to count postponed refreshes (adds rf_urgent).
package dram_pack;
  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ACTIVATE,
    READ,
    WRITE,
    PRECHARGE,
    REFRESH,
    NOP
  } cmd_fsm_t;
endpackage

module dram_timing_ctrl
  import dram_pack::*;
#(
  parameter int CNT_W  = 16,
  parameter int T_INIT = 200,
  parameter int T_RCD  = 4,
  parameter int T_RD   = 6,
  parameter int T_WR   = 8,
  parameter int T_RP   = 4,
  parameter int T_RFC  = 26,
  parameter int T_REFI = 7800
) (
  input  logic     CLK,
  input  logic     RST,
  input  cmd_fsm_t cmd_state,
  input  logic     init_req,
  output logic     init_done,
  output logic     tACT_done,
  output logic     tRD_done,
  output logic     tWR_done,
  output logic     tPRE_done,
  output logic     tREF_done,
  output logic     rf_req,
`ifdef DRAM_REF_POSTPONE_EN
  output logic     rf_urgent,
`endif
  output logic     busy
);

  if (T_INIT < 1 || T_RCD < 1 || T_RD < 1 || T_WR < 1 ||
      T_RP < 1 || T_RFC < 1 || T_REFI < 1) begin : g_bad_timing
    $error("dram_timing_ctrl: every timing parameter must be >= 1");
  end

  typedef enum logic [2:0] {
    NONE,
    OWN_ACT,
    OWN_RD,
    OWN_WR,
    OWN_PRE,
    OWN_REF
  } own_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [4:0] own_bit(own_t o);
    unique case (o)
      OWN_ACT: own_bit = 5'b00001;
      OWN_RD:  own_bit = 5'b00010;
      OWN_WR:  own_bit = 5'b00100;
      OWN_PRE: own_bit = 5'b01000;
      OWN_REF: own_bit = 5'b10000;
      default: own_bit = 5'b00000;
    endcase
  endfunction

  cmd_fsm_t         state_q;
  own_t             owner, owner_nx, issue_own;
  logic [CNT_W-1:0] cnt, cnt_nx, load_val;
  logic [4:0]       done, done_nx;
  logic             issue, ref_issue, cmd_exp;

  always_comb begin
    issue_own = NONE;
    load_val  = '0;
    unique case (cmd_state)
      ACTIVATE: begin
        issue_own = OWN_ACT;
        load_val  = CNT_W'(T_RCD - 1);
      end
      READ: begin
        issue_own = OWN_RD;
        load_val  = CNT_W'(T_RD - 1);
      end
      WRITE: begin
        issue_own = OWN_WR;
        load_val  = CNT_W'(T_WR - 1);
      end
      PRECHARGE: begin
        issue_own = OWN_PRE;
        load_val  = CNT_W'(T_RP - 1);
      end
      REFRESH: begin
        issue_own = OWN_REF;
        load_val  = CNT_W'(T_RFC - 1);
      end
      default: ;
    endcase
  end

  assign issue     = (issue_own != NONE) && (cmd_state != state_q);
  assign ref_issue = issue && (issue_own == OWN_REF);
  // Counter stepping 1->0 arms the done pulse for the following cycle
  assign cmd_exp   = (owner != NONE) && (cnt == ONE);

  always_comb begin
    owner_nx = owner;
    cnt_nx   = cnt;
    done_nx  = '0;
    if (cmd_exp) done_nx = own_bit(owner);
    if (cnt != '0) begin
      cnt_nx = cnt - ONE;
    end else begin
      owner_nx = NONE;
    end
    if (issue) begin
      owner_nx = issue_own;
      cnt_nx   = load_val;
      if (load_val == '0) done_nx = done_nx | own_bit(issue_own);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner   <= NONE;
      cnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= cmd_state;
      owner   <= owner_nx;
      cnt     <= cnt_nx;
      done    <= done_nx;
      busy    <= (owner_nx != NONE);
    end
  end

  assign tACT_done = done[0];
  assign tRD_done  = done[1];
  assign tWR_done  = done[2];
  assign tPRE_done = done[3];
  assign tREF_done = done[4];

  logic             init_q, irun;
  logic [CNT_W-1:0] icnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_q    <= 1'b0;
      irun      <= 1'b0;
      icnt      <= '0;
      init_done <= 1'b0;
    end else begin
      init_q <= init_req;
      if (!init_done) begin
        if (init_req && !init_q) begin
          icnt <= CNT_W'(T_INIT - 1);
          irun <= (T_INIT > 1);
          if (T_INIT == 1) init_done <= 1'b1;
        end else if (irun) begin
          if (!init_req) begin
            irun <= 1'b0;
          end else if (icnt == ONE) begin
            init_done <= 1'b1;
            irun      <= 1'b0;
          end else begin
            icnt <= icnt - ONE;
          end
        end
      end
    end
  end

  logic [CNT_W-1:0] rcnt;
  logic             rexp;

  assign rexp = init_done && (rcnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rcnt <= CNT_W'(T_REFI - 1);
    end else if (init_done) begin
      rcnt <= rexp ? CNT_W'(T_REFI - 1) : rcnt - ONE;
    end
  end

`ifdef DRAM_REF_POSTPONE_EN
  logic [3:0] pend, pend_nx;

  always_comb begin
    pend_nx = pend;
    if (rexp && !ref_issue) begin
      if (pend != 4'd8) pend_nx = pend + 4'd1;
    end else if (ref_issue && !rexp) begin
      if (pend != 4'd0) pend_nx = pend - 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend      <= '0;
      rf_req    <= 1'b0;
      rf_urgent <= 1'b0;
    end else begin
      pend      <= pend_nx;
      rf_req    <= (pend_nx != 4'd0);
      rf_urgent <= (pend_nx == 4'd8);
    end
  end
`else
  // A fresh interval wins over a same-cycle REFRESH issue
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_req <= 1'b0;
    end else if (rexp) begin
      rf_req <= 1'b1;
    end else if (ref_issue) begin
      rf_req <= 1'b0;
    end
  end
`endif

endmodule
